// File: rtl/pwm_regs_pkg.sv
// PWM register bank: address map, bit indices and byte-select helper.
// Shared by the bank top, its interface users and the testbench.
package pwm_regs_pkg;

  localparam logic [7:0] A_PERIOD   = 8'h00;
  localparam logic [7:0] A_CTRL     = 8'h04;
  localparam logic [7:0] A_PRESCALE = 8'h05;
  localparam logic [7:0] A_CMD      = 8'h06;
  localparam logic [7:0] A_STATUS   = 8'h07;
  localparam logic [7:0] A_CNT      = 8'h08;
  localparam logic [7:0] A_IRQF     = 8'h0C;
  localparam logic [7:0] A_IRQE     = 8'h0D;

  localparam logic [7:0] CH_BASE     = 8'h10;
  localparam logic [7:0] CH_STRIDE   = 8'h10;
  localparam logic [3:0] CH_CMP2_OFS = 4'd4;
  localparam logic [3:0] CH_FUNC_OFS = 4'd8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_UPDN  = 1;
  localparam int CTRL_PWMEN = 2;
  localparam int CMD_CRST   = 0;
  localparam int CMD_FUPD   = 1;
  localparam int IRQ_OVF    = 0;
  localparam int IRQ_UPD    = 1;

  // Bytes beyond the field width read as zero.
  function automatic logic [7:0] sel_byte(
    input logic [31:0] v,
    input logic [1:0]  i,
    input int          nb
  );
    if (int'(i) >= nb) return 8'h00;
    return v[8*i +: 8];
  endfunction

endpackage

// File: rtl/pwm_regbank_if.sv
// Byte-wide register bus between the decoder and the PWM register bank.
// The decoder is the master; the bank answers reads combinationally.
interface pwm_regbank_if;
  logic       read;
  logic       write;
  logic [7:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  modport master (
    output read, write, addr, data_write,
    input  data_read
  );

  modport slave (
    input  read, write, addr, data_write,
    output data_read
  );
endinterface

// File: rtl/pwm_shadow_reg.sv
// Byte-writable staging register with an active copy loaded on promote.
// Promotion samples staging before any same-edge byte write lands.
module pwm_shadow_reg #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W/8-1:0] we,
  input  logic [7:0]     wdata,
  input  logic           promote,
  output logic [W-1:0]   stage,
  output logic [W-1:0]   active
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage  <= '0;
      active <= '0;
    end else begin
      for (int b = 0; b < W/8; b++)
        if (we[b]) stage[b*8 +: 8] <= wdata;
      if (promote) active <= stage;
    end
  end

endmodule

// File: rtl/pwm_regbank.sv
// PWM register bank: double-buffered timing registers, control,
// command pulses, status and W1C interrupt flags.
module pwm_regbank
  import pwm_regs_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_regbank_if.slave      bus,
  input  logic [CW-1:0]     counter_val,
  input  logic              update_evt,
  input  logic              ovf_evt,
  output logic [CW-1:0]     period,
  output logic              en,
  output logic              upnotdown,
  output logic [7:0]        prescale,
  output logic              count_reset,
  output logic              pwm_en,
  output logic [NCH*CW-1:0] compare1,
  output logic [NCH*CW-1:0] compare2,
  output logic [NCH*8-1:0]  functions,
  output logic              irq
);

  localparam int NB = CW/8;

  logic          wr_ctrl, wr_pre, wr_cmd;
  logic          wr_irqf, wr_irqe;
  logic          force_upd, promote;
  logic          pending, stage_wr;
  logic [1:0]    flags, irq_en;
  logic [NB-1:0] per_we;
  logic [CW-1:0] per_stage;
  logic [3:0]    ofs;
  logic [NCH-1:0] chsel, fn_we;
  logic [NB-1:0] c1_we [NCH];
  logic [NB-1:0] c2_we [NCH];
  logic [CW-1:0] c1_stage [NCH];
  logic [CW-1:0] c2_stage [NCH];
  logic [7:0]    fn_stage [NCH];
  logic [7:0]    ch_rd;
  logic [7:0]    rdata;

  assign wr_ctrl = bus.write && bus.addr == A_CTRL;
  assign wr_pre  = bus.write && bus.addr == A_PRESCALE;
  assign wr_cmd  = bus.write && bus.addr == A_CMD;
  assign wr_irqf = bus.write && bus.addr == A_IRQF;
  assign wr_irqe = bus.write && bus.addr == A_IRQE;
  assign ofs     = bus.addr[3:0];

  assign force_upd = wr_cmd && bus.data_write[CMD_FUPD];
  assign promote   = force_upd
                   | (pending & (update_evt | ~en));

  always_comb begin
    per_we   = '0;
    chsel    = '0;
    fn_we    = '0;
    stage_wr = 1'b0;
    for (int b = 0; b < NB; b++)
      per_we[b] = bus.write
        && bus.addr == A_PERIOD + 8'(b);
    for (int c = 0; c < NCH; c++) begin
      chsel[c] = bus.addr[7:4] == 4'(c + 1);
      c1_we[c] = '0;
      c2_we[c] = '0;
      for (int b = 0; b < NB; b++) begin
        c1_we[c][b] = bus.write && chsel[c]
          && ofs == 4'(b);
        c2_we[c][b] = bus.write && chsel[c]
          && ofs == CH_CMP2_OFS + 4'(b);
      end
      fn_we[c] = bus.write && chsel[c]
        && ofs == CH_FUNC_OFS;
      stage_wr = stage_wr | (|c1_we[c])
        | (|c2_we[c]) | fn_we[c];
    end
    stage_wr = stage_wr | (|per_we);
  end

  pwm_shadow_reg #(.W(CW)) u_period (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (per_we),
    .wdata   (bus.data_write),
    .promote (promote),
    .stage   (per_stage),
    .active  (period)
  );

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pwm_shadow_reg #(.W(CW)) u_cmp1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (c1_we[c]),
      .wdata   (bus.data_write),
      .promote (promote),
      .stage   (c1_stage[c]),
      .active  (compare1[c*CW +: CW])
    );
    pwm_shadow_reg #(.W(CW)) u_cmp2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (c2_we[c]),
      .wdata   (bus.data_write),
      .promote (promote),
      .stage   (c2_stage[c]),
      .active  (compare2[c*CW +: CW])
    );
    pwm_shadow_reg #(.W(8)) u_func (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (fn_we[c]),
      .wdata   (bus.data_write),
      .promote (promote),
      .stage   (fn_stage[c]),
      .active  (functions[c*8 +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en          <= 1'b0;
      upnotdown   <= 1'b0;
      pwm_en      <= 1'b0;
      prescale    <= '0;
      irq_en      <= '0;
      flags       <= '0;
      pending     <= 1'b0;
      count_reset <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en        <= bus.data_write[CTRL_EN];
        upnotdown <= bus.data_write[CTRL_UPDN];
        pwm_en    <= bus.data_write[CTRL_PWMEN];
      end
      if (wr_pre)  prescale <= bus.data_write;
      if (wr_irqe) irq_en   <= bus.data_write[1:0];
      count_reset <= wr_cmd && bus.data_write[CMD_CRST];
      pending     <= stage_wr | (pending & ~promote);
      // Event set wins over a same-edge W1C clear.
      flags[IRQ_OVF] <= ovf_evt | (flags[IRQ_OVF]
        & ~(wr_irqf & bus.data_write[IRQ_OVF]));
      flags[IRQ_UPD] <= promote | (flags[IRQ_UPD]
        & ~(wr_irqf & bus.data_write[IRQ_UPD]));
      irq <= |(flags & irq_en);
    end
  end

  always_comb begin
    ch_rd = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chsel[c]) begin
        if (ofs < CH_CMP2_OFS)
          ch_rd = sel_byte(32'(c1_stage[c]), ofs[1:0], NB);
        else if (ofs < CH_FUNC_OFS)
          ch_rd = sel_byte(32'(c2_stage[c]), ofs[1:0], NB);
        else if (ofs == CH_FUNC_OFS)
          ch_rd = fn_stage[c];
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      bus.addr[7:2] == A_PERIOD[7:2]:
        rdata = sel_byte(32'(per_stage), bus.addr[1:0], NB);
      bus.addr == A_CTRL:
        rdata = {5'b0, pwm_en, upnotdown, en};
      bus.addr == A_PRESCALE:
        rdata = prescale;
      bus.addr == A_STATUS:
        rdata = {7'b0, pending};
      bus.addr[7:2] == A_CNT[7:2]:
        rdata = sel_byte(32'(counter_val), bus.addr[1:0], NB);
      bus.addr == A_IRQF:
        rdata = {6'b0, flags};
      bus.addr == A_IRQE:
        rdata = {6'b0, irq_en};
      |chsel:
        rdata = ch_rd;
      default:
        rdata = '0;
    endcase
  end

  assign bus.data_read = bus.read ? rdata : 8'h00;

endmodule

// File: tb/tb_pwm_regbank.sv
// Directed bench for pwm_regbank; expected values are queued by the
// stimulus and compared by a monitor whenever a read or probe is up.
module tb_pwm_regbank;
  import pwm_regs_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] counter_val = '0;
  logic update_evt = 1'b0;
  logic ovf_evt = 1'b0;
  logic [CW-1:0] period;
  logic en, upnotdown, count_reset, pwm_en, irq;
  logic [7:0] prescale;
  logic [NCH*CW-1:0] compare1, compare2;
  logic [NCH*8-1:0] functions;

  logic [7:0] period2, prescale2, functions2;
  logic [7:0] compare1_2, compare2_2;
  logic en2, upnotdown2, count_reset2, pwm_en2, irq2;

  pwm_regbank_if bus ();
  pwm_regbank_if bus2 ();

  pwm_regbank #(.NCH(NCH), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .counter_val (counter_val),
    .update_evt  (update_evt),
    .ovf_evt     (ovf_evt),
    .period      (period),
    .en          (en),
    .upnotdown   (upnotdown),
    .prescale    (prescale),
    .count_reset (count_reset),
    .pwm_en      (pwm_en),
    .compare1    (compare1),
    .compare2    (compare2),
    .functions   (functions),
    .irq         (irq)
  );

  pwm_regbank #(.NCH(1), .CW(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus2.slave),
    .counter_val (8'h00),
    .update_evt  (1'b0),
    .ovf_evt     (1'b0),
    .period      (period2),
    .en          (en2),
    .upnotdown   (upnotdown2),
    .prescale    (prescale2),
    .count_reset (count_reset2),
    .pwm_en      (pwm_en2),
    .compare1    (compare1_2),
    .compare2    (compare2_2),
    .functions   (functions2),
    .irq         (irq2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic probe = 1'b0;
  logic [31:0] act;
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] actual(input int src);
    case (src)
      0: return {24'b0, bus.data_read};
      1: return {24'b0, bus2.data_read};
      2: return {16'b0, period};
      3: return {16'b0, compare1[2*CW +: CW]};
      4: return {31'b0, count_reset};
      5: return {31'b0, irq};
      6: return {24'b0, period2};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.read || bus2.read || probe) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: output with no expectation");
      end else begin
        cur = sb.pop_front();
        act = actual(cur.src);
        if (act !== cur.exp) begin
          errors++;
          $display("FAIL %s: got %h want %h",
                   cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.write = 1'b1;
    bus.addr = a;
    bus.data_write = d;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic wr2(input logic [7:0] a, input logic [7:0] d);
    bus2.write = 1'b1;
    bus2.addr = a;
    bus2.data_write = d;
    tick();
    bus2.write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e,
                    input string n);
    sb.push_back('{src: 0, exp: {24'b0, e}, name: n});
    bus.read = 1'b1;
    bus.addr = a;
    tick();
    bus.read = 1'b0;
  endtask

  task automatic rd2(input logic [7:0] a, input logic [7:0] e,
                     input string n);
    sb.push_back('{src: 1, exp: {24'b0, e}, name: n});
    bus2.read = 1'b1;
    bus2.addr = a;
    tick();
    bus2.read = 1'b0;
  endtask

  task automatic chk(input int s, input logic [31:0] e,
                     input string n);
    sb.push_back('{src: s, exp: e, name: n});
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  initial begin
    bus.read = 0; bus.write = 0;
    bus.addr = 0; bus.data_write = 0;
    bus2.read = 0; bus2.write = 0;
    bus2.addr = 0; bus2.data_write = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    for (int a = 0; a < 14; a++)
      rd(8'(a), 8'h00, $sformatf("rst_reg_%0h", a));
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < 9; o++)
        rd(CH_BASE + 8'(c) * CH_STRIDE + 8'(o), 8'h00,
           $sformatf("rst_ch%0d_%0d", c, o));
    chk(5, 0, "rst_irq");
    chk(4, 0, "rst_count_reset");
    chk(2, 0, "rst_period");

    // buffered period, promoted at update_evt
    wr(A_CTRL, 8'h01);
    wr(A_PERIOD, 8'h34);
    wr(A_PERIOD + 8'd1, 8'h12);
    chk(2, 0, "period_held");
    rd(A_STATUS, 8'h01, "status_pending");
    update_evt = 1'b1;
    tick();
    update_evt = 1'b0;
    chk(2, 32'h1234, "period_promoted");
    rd(A_STATUS, 8'h00, "status_cleared");
    rd(A_IRQF, 8'h02, "irqf_update_done");
    rd(A_PERIOD, 8'h34, "period_stage_rd");

    // en=0 promotes without update_evt
    wr(A_CTRL, 8'h00);
    wr(8'h30, 8'hAA);
    tick();
    chk(3, 32'h00AA, "cmp1_ch2_auto");
    rd(8'h30, 8'hAA, "cmp1_ch2_rd");
    rd(A_STATUS, 8'h00, "status_auto");

    // count_reset pulse
    wr(A_CMD, 8'h01);
    chk(4, 1, "crst_high");
    chk(4, 0, "crst_low");
    rd(A_CMD, 8'h00, "cmd_reads0");
    wr(A_CMD, 8'h01);
    wr(A_CMD, 8'h01);
    chk(4, 1, "crst_ext_high");
    chk(4, 0, "crst_ext_low");

    // irq flags/enable
    wr(A_IRQE, 8'h01);
    ovf_evt = 1'b1;
    tick();
    ovf_evt = 1'b0;
    tick();
    chk(5, 1, "irq_ovf");
    bus.write = 1'b1;
    bus.addr = A_IRQF;
    bus.data_write = 8'h01;
    ovf_evt = 1'b1;
    tick();
    bus.write = 1'b0;
    ovf_evt = 1'b0;
    rd(A_IRQF, 8'h03, "irqf_set_wins");
    chk(5, 1, "irq_still");
    wr(A_IRQF, 8'h01);
    tick();
    chk(5, 0, "irq_cleared");
    rd(A_IRQF, 8'h02, "irqf_after_clr");

    // staging write coincident with promotion
    wr(A_CTRL, 8'h01);
    wr(A_PERIOD + 8'd1, 8'h77);
    bus.write = 1'b1;
    bus.addr = A_PERIOD;
    bus.data_write = 8'h56;
    update_evt = 1'b1;
    tick();
    bus.write = 1'b0;
    update_evt = 1'b0;
    chk(2, 32'h7734, "coincide_active_old");
    rd(A_STATUS, 8'h01, "coincide_pending");
    rd(A_PERIOD, 8'h56, "coincide_stage");
    wr(A_CMD, 8'h02);
    chk(2, 32'h7756, "force_update");
    rd(A_STATUS, 8'h00, "force_status");

    // unmapped / out-of-range
    rd(8'hFF, 8'h00, "unmapped_ff");
    rd(8'h0E, 8'h00, "unmapped_0e");
    wr(8'h50, 8'h99);
    rd(8'h50, 8'h00, "ch_beyond_nch");
    wr(A_PERIOD + 8'd3, 8'h11);
    rd(A_PERIOD + 8'd3, 8'h00, "period_b3_cw16");
    rd(A_STATUS, 8'h00, "ignored_no_pending");
    counter_val = 16'hBEEF;
    rd(A_CNT, 8'hEF, "cnt_b0");
    rd(A_CNT + 8'd1, 8'hBE, "cnt_b1");
    rd(A_CNT + 8'd2, 8'h00, "cnt_b2");

    // CW=8 instance
    wr2(A_PERIOD + 8'd1, 8'h55);
    rd2(A_PERIOD + 8'd1, 8'h00, "cw8_period_b1");
    wr2(A_PERIOD, 8'h66);
    rd2(A_PERIOD, 8'h66, "cw8_period_b0");
    chk(6, 32'h66, "cw8_period_active");

    // reset discards pending staging
    wr(A_PERIOD, 8'h11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk(2, 0, "rst_mid_period");
    rd(A_STATUS, 8'h00, "rst_mid_status");
    rd(A_PERIOD, 8'h00, "rst_mid_stage");

    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
